// File: rtl/serial_link_ctrl.sv
// serial_link_ctrl: frame-level sequencer for the loopback serial link
// (TX FIFO -> PISO -> SIPO -> RX FIFO). One word per frame: pop, load,
// shift DATA_W bits, push. Keeps a wrapping count of completed frames.
`timescale 1ns/1ps
module serial_link_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tx_empty,
  input  logic             rx_full,
  output logic             tx_rd,
  output logic             piso_load,
  output logic             shift_en,
  output logic             sipo_en,
  output logic             rx_wr,
  output logic             busy,
  output logic             stall,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    STORE = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [CNT_W-1:0] frame_cnt_reg;

  // State register; reset abandons any in-flight frame.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Bit counter: cleared while loading, advances once per shifted bit.
  always_ff @(posedge clk) begin
    if (rst)                     bit_cnt_reg <= '0;
    else if (state_reg == LOAD)  bit_cnt_reg <= '0;
    else if (state_reg == SHIFT) bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
  end

  // Completed-frame counter, bumped on every RX push, wraps silently.
  always_ff @(posedge clk) begin
    if (rst)        frame_cnt_reg <= '0;
    else if (rx_wr) frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
  end

  // Next-state logic; en/tx_empty only matter at a frame boundary.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (en && !tx_empty) state_next = FETCH;
      FETCH: state_next = LOAD;
      LOAD:  state_next = SHIFT;
      SHIFT: if (bit_cnt_reg == LAST_BIT) state_next = STORE;
      STORE: begin
        if (!rx_full) state_next = (en && !tx_empty) ? FETCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from registered state; only rx_wr/stall see rx_full.
  always_comb begin
    tx_rd     = 1'b0;
    piso_load = 1'b0;
    shift_en  = 1'b0;
    rx_wr     = 1'b0;
    stall     = 1'b0;
    busy      = (state_reg != IDLE);
    case (state_reg)
      FETCH: tx_rd     = 1'b1;
      LOAD:  piso_load = 1'b1;
      SHIFT: shift_en  = 1'b1;
      STORE: begin
        rx_wr = !rx_full;
        stall = rx_full;
      end
      default: ;
    endcase
    sipo_en = shift_en;
  end

  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_serial_link_ctrl.sv
// Bench for serial_link_ctrl: models the FIFO/PISO/SIPO loop around the
// controller; expected frames go into scoreboard queues when issued and a
// negedge monitor pops and compares on each tx_rd / rx_wr.
`timescale 1ns/1ps
module tb_serial_link_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       tx_empty;
  logic       rx_full = 1'b0;
  logic       tx_rd, piso_load, shift_en, sipo_en, rx_wr, busy, stall;
  logic [3:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
    int         cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         rd_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] fifo_dout = 8'h00;
  logic [7:0] piso = 8'h00;
  logic [7:0] sipo = 8'h00;
  int         nshift = 0;

  serial_link_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .tx_empty(tx_empty), .rx_full(rx_full),
    .tx_rd(tx_rd), .piso_load(piso_load), .shift_en(shift_en),
    .sipo_en(sipo_en), .rx_wr(rx_wr), .busy(busy), .stall(stall),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_empty = (tx_q.size() == 0);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Advance to #1 after the posedge that starts cycle c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Arrive at the negedge inside cycle c (sampling point).
  task automatic at_neg(input int c);
    goto(c);
    @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input int rd_c, input int wr_c, input int cnt);
    tx_q.push_back(d);
    rd_q.push_back(rd_c);
    exp_q.push_back('{data: d, cyc: wr_c, cnt: cnt});
  endtask

  // Shift-register model of the PISO -> SIPO loopback.
  initial forever begin
    @(posedge clk);
    if (piso_load) piso = fifo_dout;
    else if (shift_en) begin
      sipo = {sipo[6:0], piso[7]};
      piso = {piso[6:0], 1'b0};
    end
  end

  // Monitor: FIFO pop, invariants, and scoreboard comparisons.
  initial forever begin
    @(negedge clk);
    if (cyc >= 1) begin
      checks++;
      if (($countones({tx_rd, piso_load, shift_en, rx_wr}) > 1) ||
          (sipo_en != shift_en) || (rx_wr && rx_full)) begin
        errors++;
        $display("FAIL invariant cyc=%0d rd=%0b ld=%0b sh=%0b si=%0b wr=%0b full=%0b",
                 cyc, tx_rd, piso_load, shift_en, sipo_en, rx_wr, rx_full);
      end
    end
    if (piso_load) nshift = 0;
    if (shift_en) nshift++;
    if (tx_rd) begin
      if (tx_q.size() > 0) fifo_dout = tx_q.pop_front();
      if (rd_q.size() == 0) chk("unexpected_tx_rd", cyc, -1);
      else chk("tx_rd_cyc", cyc, rd_q.pop_front());
    end
    if (rx_wr) begin
      if (exp_q.size() == 0) chk("unexpected_rx_wr", cyc, -1);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_wr_cyc", cyc, e.cyc);
        chk("rx_data", int'(sipo), int'(e.data));
        chk("cnt_before_wr", int'(frame_cnt), e.cnt);
        chk("shift_count", nshift, 8);
        $display("frame data=%02h cyc=%0d cnt=%0d", sipo, cyc, frame_cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    // Reset and idle with an empty TX FIFO.
    at_neg(1);
    chk("reset_outs", {tx_rd, piso_load, shift_en, sipo_en, rx_wr, busy, stall}, 0);
    chk("reset_cnt", frame_cnt, 0);
    goto(2);
    rst = 1'b0;
    en = 1'b1;
    for (int c = 3; c <= 22; c++) begin
      at_neg(c);
      chk("idle_outs", {tx_rd, piso_load, shift_en, sipo_en, rx_wr, busy, stall}, 0);
      chk("idle_cnt", frame_cnt, 0);
    end

    // Abort: reset during the 4th shift cycle (30), no rx_wr follows.
    goto(24);
    tx_q.push_back(8'h99);
    rd_q.push_back(25);
    goto(30);
    rst = 1'b1;
    en = 1'b0;
    at_neg(30);
    chk("abort_shift4", shift_en, 1);
    goto(31);
    rst = 1'b0;
    at_neg(31);
    chk("abort_outs", {tx_rd, piso_load, shift_en, sipo_en, rx_wr, busy, stall}, 0);
    chk("abort_cnt", frame_cnt, 0);

    // Single frame: tx_empty falls in cycle 40.
    goto(39);
    en = 1'b1;
    goto(40);
    frame(8'h12, 41, 51, 0);
    at_neg(42); chk("single_load", piso_load, 1);
    at_neg(43); chk("single_shift_first", {shift_en, sipo_en}, 3);
    at_neg(50); chk("single_shift_last", shift_en, 1);
    at_neg(51); chk("single_noshift_store", shift_en, 0);
    chk("single_busy_store", busy, 1);
    at_neg(52); chk("single_idle", busy, 0);
    chk("single_cnt", frame_cnt, 1);

    // Back-to-back: three words, 11-cycle period.
    goto(60);
    frame(8'hA5, 61, 71, 1);
    frame(8'h3C, 72, 82, 2);
    frame(8'hFF, 83, 93, 3);
    lows = 0;
    for (int c = 61; c <= 93; c++) begin
      at_neg(c);
      if (!busy) lows++;
    end
    chk("b2b_busy_gaps", lows, 0);
    at_neg(94); chk("b2b_idle", busy, 0);
    chk("b2b_cnt", frame_cnt, 4);

    // Backpressure: rx_full for 5 cycles from the STORE cycle (111).
    goto(100);
    frame(8'h5A, 101, 116, 4);
    at_neg(110); chk("bp_last_shift", shift_en, 1);
    goto(111);
    rx_full = 1'b1;
    for (int c = 111; c <= 115; c++) begin
      at_neg(c);
      chk("bp_stall_outs", {stall, rx_wr, shift_en}, 3'b100);
    end
    goto(116);
    rx_full = 1'b0;
    at_neg(116); chk("bp_stall_clear", stall, 0);
    at_neg(117); chk("bp_cnt", frame_cnt, 5);

    // en dropped mid-shift: frame completes, then idle with data waiting.
    goto(130);
    frame(8'h81, 131, 141, 5);
    tx_q.push_back(8'h42);
    goto(135);
    en = 1'b0;
    at_neg(142); chk("endrop_idle", busy, 0);
    at_neg(150); chk("endrop_still_idle", {busy, tx_rd}, 0);
    chk("endrop_cnt", frame_cnt, 6);

    // Wrap with CNT_W=4: 17 frames after a reset, 0x42 goes first.
    goto(152);
    rst = 1'b1;
    goto(153);
    rst = 1'b0;
    goto(155);
    rd_q.push_back(156);
    exp_q.push_back('{data: 8'h42, cyc: 166, cnt: 0});
    for (int k = 1; k <= 16; k++)
      frame(8'(k * 13 + 1), 156 + 11 * k, 166 + 11 * k, k % 16);
    en = 1'b1;
    at_neg(343);
    chk("wrap_cnt_after17", frame_cnt, 1);
    chk("wrap_idle", busy, 0);

    at_neg(350);
    chk("pending_rx_wr", exp_q.size(), 0);
    chk("pending_tx_rd", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
